rr_grant_4: RTL and testbench

Four-way round-robin grant responder. It is the answering end of the four-line request bus whose lines are merged by the delayed 4-input OR into a single "any request" signal. The block samples the four requests, issues exactly one registered one-hot grant, holds it until the granted requester releases, then rotates priority. It sits between the lab's requesting units and the shared resource they contend for.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_prio_pick.sv | 32 +++
 rtl/rr_grant_4.sv | 136 +++++++++++++
 tb/tb_rr_grant_4.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin grant responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ             = 4;
  localparam int ID_W             = 2;
  localparam int CNT_W            = 8;
  localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority picker: first set request searching ptr, ptr+1, ... mod NREQ.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever any request is set.
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [ID_W-1:0] pick_id,
  output logic            pick_valid
);

  logic [ID_W-1:0] idx;

  // Walk the request lines starting at ptr; the ID_W-bit add wraps mod 4.
  always_comb begin
    pick       = '0;
    pick_id    = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
        pick[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_4.sv
// Four-way round-robin grant responder, one registered one-hot grant held until release.
// Latency: grant 1 cycle after request sampled in IDLE; one idle cycle between grants.
// Backpressure: non-granted requesters simply wait; optional GRANT_TIMEOUT_EN forces release after MAX_HOLD cycles.
module rr_grant_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            any_req,
  output logic            timeout
);

  // Reject out-of-range hold limits at elaboration.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_grant_4: MAX_HOLD must be in 2..255");
  end

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            gv_q, gv_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] pick;
  logic [ID_W-1:0] pick_id;
  logic            pick_valid;
`ifdef GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_prio_pick u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .pick       (pick),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // Next-state: grant from IDLE, hold in GRANT until holder drops (or hold limit hits).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gv_d    = gv_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef GRANT_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = pick;
          gv_d    = 1'b1;
          id_d    = pick_id;
          ptr_d   = pick_id + ID_W'(1);
`ifdef GRANT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
          id_d    = '0;
`ifdef GRANT_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          // Holder overstayed: force release; ptr already points past it.
          state_d   = IDLE;
          grant_d   = '0;
          gv_d      = 1'b0;
          id_d      = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gv_d    = 1'b0;
        id_d    = '0;
      end
    endcase
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign grant_id    = id_q;
  assign any_req     = |req;

endmodule

// File: tb/tb_rr_grant_4.sv
module tb_rr_grant_4;
  import arb_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            any_req;
  logic            timeout;

  int checks;
  int errors;

  rr_grant_4 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .any_req     (any_req),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Wait n cycles; always returns just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    chk({tag, ".id"},    {6'b0, grant_id}, {6'b0, id});
    chk({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, |g});
  endtask

  logic [3:0] order [5];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // Reset state
    step(3);
    chk_grant("rst", 4'b0000, 2'd0);
    chk("rst.timeout", {7'b0, timeout}, 8'd0);
    chk("rst.any_req", {7'b0, any_req}, 8'd0);
    rst_n = 1'b1;
    step(1);

    // Single requester: grant after first edge, release after the edge that sees req low
    req = 4'b0100;
    #1 chk("single.any_req", {7'b0, any_req}, 8'd1);
    step(1);
    chk_grant("single.e1", 4'b0100, 2'd2);
    step(3);
    chk_grant("single.e4", 4'b0100, 2'd2);
    req = 4'b0000;
    step(1);
    chk_grant("single.rel", 4'b0000, 2'd0);

    // Pointer wrap: ptr=3 grants 3, then ptr=0 prefers 0 over 3
    req = 4'b1000;
    step(1);
    chk_grant("wrap.g3", 4'b1000, 2'd3);
    req = 4'b0000;
    step(1);
    req = 4'b1001;
    step(1);
    chk_grant("wrap.g0", 4'b0001, 2'd0);
    req = 4'b0000;
    step(1);
    chk_grant("wrap.rel", 4'b0000, 2'd0);

    // No preemption: requester 1 holds while 0 waits; idle cycle before 0 wins
    req = 4'b0010;
    step(1);
    chk_grant("nopre.g1", 4'b0010, 2'd1);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_grant("nopre.hold", 4'b0010, 2'd1);
    end
    req = 4'b0001;
    step(1);
    chk_grant("nopre.idle", 4'b0000, 2'd0);
    step(1);
    chk_grant("nopre.g0", 4'b0001, 2'd0);
    req = 4'b0000;
    step(1);

    // Reset mid-grant: immediate clear, ptr back to 0 (ptr would otherwise be 2)
    req = 4'b0010;
    step(1);
    chk_grant("mid.g1", 4'b0010, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_grant("mid.rst", 4'b0000, 2'd0);
    chk("mid.timeout", {7'b0, timeout}, 8'd0);
    step(1);
    rst_n = 1'b1;
    req   = 4'b1111;
    step(1);

    // Contention rotation with re-raising holders
    for (int k = 0; k < 5; k++) begin
      chk_grant($sformatf("rot%0d.c1", k), order[k], 2'(k % 4));
      step(1);
      chk_grant($sformatf("rot%0d.c2", k), order[k], 2'(k % 4));
      req = 4'b1111 & ~order[k];
      step(1);
      chk_grant($sformatf("rot%0d.idle", k), 4'b0000, 2'd0);
      req = 4'b1111;
      if (k < 4) step(1);
    end
    req = 4'b0000;
    step(2);

    // Lone holder that never releases
    req = 4'b0001;
    step(1);
`ifdef GRANT_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk_grant($sformatf("to.hold%0d", i), 4'b0001, 2'd0);
      chk($sformatf("to.pulse%0d", i), {7'b0, timeout}, 8'd0);
      step(1);
    end
    chk_grant("to.rel", 4'b0000, 2'd0);
    chk("to.pulse", {7'b0, timeout}, 8'd1);
    step(1);
    chk_grant("to.regrant", 4'b0001, 2'd0);
    chk("to.pulse_end", {7'b0, timeout}, 8'd0);
`else
    for (int i = 0; i < 100; i++) begin
      chk_grant($sformatf("hold%0d", i), 4'b0001, 2'd0);
      chk($sformatf("hold%0d.timeout", i), {7'b0, timeout}, 8'd0);
      step(1);
    end
`endif
    req = 4'b0000;
    step(1);
    chk_grant("end.rel", 4'b0000, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
